// File: rtl/kbd_move_pkg.sv
// Shared types, scan-code constants and the key-to-move mapping function
// used by kbd_move_queue and its command FIFO.
package kbd_move_pkg;

    typedef enum logic [2:0] {
        MV_UP     = 3'd0,
        MV_DOWN   = 3'd1,
        MV_LEFT   = 3'd2,
        MV_RIGHT  = 3'd3,
        MV_ACTION = 3'd4
    } move_t;

    localparam int unsigned EXT_BIT  = 8;
    localparam int unsigned N_MOVES  = 5;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [8:0] SC_SPACE = 9'h029;

    typedef struct packed {
        logic  hit;
        move_t mv;
    } map_t;

    // Direction codes match with the E0 prefix, or without it when keypad
    // mapping is enabled; space must match all nine bits.
    function automatic map_t map_scan(input logic [8:0] code, input logic accept_keypad);
        map_t r;
        r.hit = 1'b0;
        r.mv  = MV_UP;
        if (code == SC_SPACE) begin
            r.hit = 1'b1;
            r.mv  = MV_ACTION;
        end else if (code[EXT_BIT] || accept_keypad) begin
            case (code[7:0])
                SC_UP:    begin r.hit = 1'b1; r.mv = MV_UP;    end
                SC_DOWN:  begin r.hit = 1'b1; r.mv = MV_DOWN;  end
                SC_LEFT:  begin r.hit = 1'b1; r.mv = MV_LEFT;  end
                SC_RIGHT: begin r.hit = 1'b1; r.mv = MV_RIGHT; end
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// First-word fall-through FIFO of move commands; DEPTH must be a power of two.
// Reports a dropped push when full and not popping in the same cycle.
module move_fifo
    import kbd_move_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push_i,
    input  move_t data_i,
    input  logic  pop_i,
    output logic  empty_o,
    output logic  full_o,
    output move_t head_o,
    output logic  drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    move_t          mem_q [DEPTH];
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_pop;
    logic           do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot this same push needs, so full only blocks without one.
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & full_o & ~do_pop;
    assign head_o  = empty_o ? MV_UP : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/kbd_move_queue.sv
// Turns keyboard make/brake events into queued frog-move commands with
// per-key held tracking. Define KBD_MOVE_REPEAT_EN to queue typematic repeats.
module kbd_move_queue
    import kbd_move_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ACCEPT_KEYPAD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] key_Pressed,
    input  logic       make,
    input  logic       brake,
    output logic       move_valid,
    output logic [2:0] move_code,
    input  logic       move_ready,
    output logic [4:0] held,
    output logic       overflow
);

    map_t        map;
    logic        ev_make;
    logic        ev_brake;
    logic        push;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_drop;
    move_t       fifo_head;
    logic [4:0]  held_q, held_d;
    logic        overflow_q, overflow_d;

    assign map      = map_scan(key_Pressed, ACCEPT_KEYPAD != 0);
    assign ev_make  = make & ~brake & map.hit;
    assign ev_brake = brake & ~make & map.hit;

    always_comb begin
        held_d = held_q;
        push   = 1'b0;
        if (ev_make) begin
            if (!held_q[map.mv]) begin
                held_d[map.mv] = 1'b1;
                push           = 1'b1;
            end else begin
`ifdef KBD_MOVE_REPEAT_EN
                push = 1'b1;
`else
                push = 1'b0;
`endif
            end
        end
        if (ev_brake) begin
            held_d[map.mv] = 1'b0;
        end
    end

    assign overflow_d = overflow_q | fifo_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    move_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .data_i (map.mv),
        .pop_i  (move_ready),
        .empty_o(fifo_empty),
        .full_o (fifo_full),
        .head_o (fifo_head),
        .drop_o (fifo_drop)
    );

    assign move_valid = ~fifo_empty;
    assign move_code  = fifo_head;
    assign held       = held_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_move_queue.sv
// Bench for kbd_move_queue: two instances (keypad mapping on/off) share the
// stimulus and are compared against a queue-based reference model each cycle.
module tb_kbd_move_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] key;
    logic       make;
    logic       brake;
    logic       ready;

    logic       mvalid [2];
    logic [2:0] mcode  [2];
    logic [4:0] mheld  [2];
    logic       movf   [2];

    int checks   = 0;
    int failures = 0;

    logic [4:0] mh [2];
    bit         mo [2];
    int         mq [2][$];

    always #5 clk = ~clk;

    kbd_move_queue #(.DEPTH(DEPTH), .ACCEPT_KEYPAD(1)) dut (
        .clk(clk), .reset(reset), .key_Pressed(key), .make(make), .brake(brake),
        .move_valid(mvalid[0]), .move_code(mcode[0]), .move_ready(ready),
        .held(mheld[0]), .overflow(movf[0])
    );

    kbd_move_queue #(.DEPTH(DEPTH), .ACCEPT_KEYPAD(0)) dut_nk (
        .clk(clk), .reset(reset), .key_Pressed(key), .make(make), .brake(brake),
        .move_valid(mvalid[1]), .move_code(mcode[1]), .move_ready(ready),
        .held(mheld[1]), .overflow(movf[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_map(input logic [8:0] c, input bit kp);
        case (c)
            9'h175: return 0;
            9'h172: return 1;
            9'h16B: return 2;
            9'h174: return 3;
            9'h029: return 4;
            9'h075: return kp ? 0 : -1;
            9'h072: return kp ? 1 : -1;
            9'h06B: return kp ? 2 : -1;
            9'h074: return kp ? 3 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = '0;
            mo[k] = 1'b0;
            mq[k].delete();
        end
    endtask

    task automatic model_step(input logic [8:0] c, input logic mk, input logic br, input logic rdy);
        for (int k = 0; k < 2; k++) begin
            int d;
            bit do_push;
            d = ref_map(c, k == 0);
            do_push = 1'b0;
            if (d >= 0 && mk && !br) begin
                if (!mh[k][d]) begin
                    mh[k][d] = 1'b1;
                    do_push  = 1'b1;
                end else begin
`ifdef KBD_MOVE_REPEAT_EN
                    do_push = 1'b1;
`endif
                end
            end
            if (d >= 0 && br && !mk) mh[k][d] = 1'b0;
            if (rdy && mq[k].size() > 0) void'(mq[k].pop_front());
            if (do_push) begin
                if (mq[k].size() < DEPTH) mq[k].push_back(d);
                else mo[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid%0d", k), int'(mvalid[k]), int'(mq[k].size() > 0));
            check($sformatf("code%0d", k), int'(mcode[k]), (mq[k].size() > 0) ? mq[k][0] : 0);
            check($sformatf("held%0d", k), int'(mheld[k]), int'(mh[k]));
            check($sformatf("ovf%0d", k), int'(movf[k]), int'(mo[k]));
        end
    endtask

    // Called at a negedge: compare current outputs, then drive one cycle.
    task automatic step(input logic [8:0] c, input logic mk, input logic br, input logic rdy);
        compare_all();
        key   = c;
        make  = mk;
        brake = br;
        ready = rdy;
        model_step(c, mk, br, rdy);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(9'h000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [8:0] codes [12];
        int n;
        codes = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h075, 9'h072,
                  9'h06B, 9'h074, 9'h029, 9'h01C, 9'h129, 9'h000};

        reset = 1'b1; key = '0; make = 1'b0; brake = 1'b0; ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", int'(mvalid[0]), 0);
        check("rst_code", int'(mcode[0]), 0);
        check("rst_held", int'(mheld[0]), 0);
        check("rst_ovf", int'(movf[0]), 0);
        reset = 1'b0;
        @(negedge clk);

        // single UP press, then consume it
        step(9'h175, 1'b1, 1'b0, 1'b0);
        check("up_valid", int'(mvalid[0]), 1);
        check("up_code", int'(mcode[0]), 0);
        check("up_held", int'(mheld[0]), 5'b00001);
        step(9'h000, 1'b0, 1'b0, 1'b1);
        check("up_popped", int'(mvalid[0]), 0);
        step(9'h175, 1'b0, 1'b1, 1'b0);

        // typematic repeat on LEFT
        step(9'h16B, 1'b1, 1'b0, 1'b0);
        check("left_held", int'(mheld[0][2]), 1);
        repeat (3) step(9'h16B, 1'b1, 1'b0, 1'b0);
        step(9'h16B, 1'b0, 1'b1, 1'b0);
        check("left_released", int'(mheld[0][2]), 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (mvalid[0]) n++;
            step(9'h000, 1'b0, 1'b0, 1'b1);
        end
`ifdef KBD_MOVE_REPEAT_EN
        check("left_count", n, 4);
`else
        check("left_count", n, 1);
`endif

        // keypad 8 is UP only on the keypad-enabled instance
        step(9'h075, 1'b1, 1'b0, 1'b0);
        check("kp_on_valid", int'(mvalid[0]), 1);
        check("kp_off_valid", int'(mvalid[1]), 0);
        check("kp_off_held", int'(mheld[1]), 0);
        step(9'h075, 1'b0, 1'b1, 1'b0);
        drain(2);

        // overflow: five commands into a four-deep queue
        for (int d = 0; d < 5; d++) begin
            step(codes[d == 4 ? 8 : d], 1'b1, 1'b0, 1'b0);
            step(codes[d == 4 ? 8 : d], 1'b0, 1'b1, 1'b0);
        end
        check("ovf_set", int'(movf[0]), 1);
        drain(5);
        check("ovf_sticky", int'(movf[0]), 1);

        // asynchronous reset with entries queued and keys held
        step(9'h175, 1'b1, 1'b0, 1'b0);
        step(9'h172, 1'b1, 1'b0, 1'b0);
        compare_all();
        make = 1'b0; brake = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", int'(mvalid[0]), 0);
        check("arst_held", int'(mheld[0]), 0);
        check("arst_ovf", int'(movf[0]), 0);
        check("arst_held_nk", int'(mheld[1]), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // full queue, push and pop in the same cycle
        step(9'h175, 1'b1, 1'b0, 1'b0); step(9'h175, 1'b0, 1'b1, 1'b0);
        step(9'h172, 1'b1, 1'b0, 1'b0); step(9'h172, 1'b0, 1'b1, 1'b0);
        step(9'h16B, 1'b1, 1'b0, 1'b0); step(9'h16B, 1'b0, 1'b1, 1'b0);
        step(9'h029, 1'b1, 1'b0, 1'b0);
        step(9'h174, 1'b1, 1'b0, 1'b1);
        check("fullpop_ovf", int'(movf[0]), 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (mvalid[0]) n++;
            step(9'h000, 1'b0, 1'b0, 1'b1);
        end
        check("fullpop_cnt", n, 4);

        // unmapped code and simultaneous make/brake are ignored
        step(9'h01C, 1'b1, 1'b0, 1'b0);
        step(9'h01C, 1'b0, 1'b1, 1'b0);
        check("unmapped_valid", int'(mvalid[0]), 0);
        step(9'h174, 1'b1, 1'b1, 1'b0);
        check("both_valid", int'(mvalid[0]), 0);

        // randomized traffic with alternating drain pressure
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] c;
            int r;
            bit mk, br, rdy;
            c = codes[$urandom_range(0, 11)];
            if (c == 9'h000) c = 9'($urandom);
            r  = int'($urandom_range(0, 7));
            mk = (r <= 2) || (r == 5);
            br = (r == 3) || (r == 4) || (r == 5);
            rdy = $urandom_range(0, 99) < (((i / 300) % 2) != 0 ? 80 : 20);
            step(c, mk, br, rdy);
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kbd_move_queue.md
Name: kbd_move_queue

Overview:
- Sits directly downstream of the keyboard interface and consumes its decoded scan-code stream: key_Pressed[8:0], make and brake.
- Converts arrow / keypad / space key events into discrete frog-move commands.
- Tracks the held state of each mapped key and suppresses typematic repeats.
- Buffers commands in a small FIFO that the game logic drains through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ACCEPT_KEYPAD, 1, 1 = non-extended keypad 8/2/4/6 also map to moves; 0 = only E0-prefixed arrow keys map.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_Pressed  in  9  bit8 = E0 extended prefix, bits7:0 = scan code; sampled only when make or brake is 1
- make  in  1  single-cycle pulse: key_Pressed was pressed
- brake  in  1  single-cycle pulse: key_Pressed was released
- move_valid  out  1  FIFO head holds a command
- move_code  out  3  head command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ACTION
- move_ready  in  1  consumer accepts the head this cycle
- held  out  5  current held state, one bit per command (bit index = code)
- overflow  out  1  sticky flag: a command was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high): held=0, FIFO empty, move_valid=0, move_code=0, overflow=0. Reset mid-operation discards queued commands and held state immediately.
- Key map, combinational on key_Pressed:
  - UP: 0x175; DOWN: 0x172; LEFT: 0x16B; RIGHT: 0x174.
  - If ACCEPT_KEYPAD=1, the same map also applies to 0x075, 0x072, 0x06B, 0x074.
  - ACTION: 0x029.
  - Any other code is unmapped; its events are ignored with no state change.
- Event classification, per cycle:
  - make=1, brake=0, mapped code c:
    - if held[c]=0: set held[c], push c.
    - if held[c]=1: typematic repeat, dropped (see Optional Feature).
  - brake=1, make=0, mapped code c: clear held[c]; nothing pushed. Clearing an already clear bit is harmless.
  - make=1 and brake=1 together: protocol error; ignored entirely.
  - If both the keypad and arrow variant of one direction are pressed, they share one held bit. The first release clears it.
- FIFO, registered, first-word fall-through:
  - push at cycle N -> move_valid=1 and move_code valid at N+1 when the FIFO was empty. Latency 1 cycle.
  - pop occurs when move_valid & move_ready. The head advances at the next edge.
  - move_ready while empty: no effect.
  - push while full with no pop in the same cycle: command dropped, overflow set to 1.
  - push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - push and pop in the same cycle while empty: no pop (move_valid=0); push stored.
  - Read/write pointers wrap modulo DEPTH. An occupancy count of log2(DEPTH)+1 bits distinguishes full from empty.
  - overflow is cleared only by reset.
- held bits update at the edge after the event and are independent of FIFO state. A dropped push still updates held.

Optional Feature:
- Macro KBD_MOVE_REPEAT_EN.
- Defined: a make on an already-held mapped key pushes c again, so typematic repeat produces continuous movement. held is unchanged.
- Undefined: repeats are silently dropped as above. The repeat path is not synthesized.

Decomposition:
- Package kbd_move_pkg:
  - move_t enum (MV_UP..MV_ACTION, 3 bits).
  - Scan-code constants SC_UP/SC_DOWN/SC_LEFT/SC_RIGHT (8-bit) and SC_SPACE.
  - EXT_BIT index 8.
  - Mapping function map_scan(code[8:0], accept_keypad) returning {hit, move_t}.
- Sub-module move_fifo: parameterised DEPTH×3-bit FWFT FIFO with push/pop/full/empty. kbd_move_queue contains only the mapping, held register, repeat filter and overflow flag.

Test Plan:
- Reset, then make 0x175 with move_ready=0 -> next cycle move_valid=1, move_code=0, held=5'b00001. Then assert move_ready one cycle -> move_valid=0.
- make 0x16B, three further make 0x16B, then brake 0x16B -> exactly one LEFT queued; held[2] 1 then 0. With KBD_MOVE_REPEAT_EN: four LEFT entries queued.
- ACCEPT_KEYPAD=0: make 0x075 -> nothing queued, held unchanged. ACCEPT_KEYPAD=1: same stimulus -> UP queued.
- DEPTH=4, move_ready=0, push UP, DOWN, LEFT, RIGHT, ACTION (each key released in between) -> head order 0,1,2,3; ACTION dropped; overflow=1 and stays 1 after draining.
- FIFO full, make RIGHT in the same cycle as move_ready=1 -> head pops, RIGHT appended, overflow stays 0, count stays 4.
- Assert reset asynchronously mid-stream with two entries queued and keys held -> move_valid, held and overflow go to 0 immediately without a clock edge. Unmapped code 0x01C make/brake -> no change.
